// File: rtl/tsn_csr_pkg.sv
// Shared types and constants for the TSN CSR fabric: router FSM states,
// Avalon response codes and the default abort timeout.
package tsn_csr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ACK,
    RDWAIT,
    RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/tsn_csr_port_mux.sv
// Selects one slave port's readdata, readdatavalid and waitrequest by index.
// An out-of-range index looks like a stalled, silent port.
module tsn_csr_port_mux #(
  parameter int NUM_PORT = 5,
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 3
) (
  input  logic [SEL_W-1:0]           i_sel,
  input  logic [NUM_PORT*DATA_W-1:0] i_readdata,
  input  logic [NUM_PORT-1:0]        i_readdatavalid,
  input  logic [NUM_PORT-1:0]        i_waitrequest,
  output logic [DATA_W-1:0]          o_readdata,
  output logic                       o_readdatavalid,
  output logic                       o_waitrequest
);

  always_comb begin
    o_readdata      = '0;
    o_readdatavalid = 1'b0;
    o_waitrequest   = 1'b1;
    for (int k = 0; k < NUM_PORT; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_readdata      = i_readdata[k*DATA_W +: DATA_W];
        o_readdatavalid = i_readdatavalid[k];
        o_waitrequest   = i_waitrequest[k];
      end
    end
  end

endmodule

// File: rtl/tsn_csr_router.sv
// Avalon-MM CSR router: decodes host address into fixed slave windows plus a reserved
// port, forwards one transaction at a time and aborts with SLVERR on slave timeout.
module tsn_csr_router
  import tsn_csr_pkg::*;
#(
  parameter int NUM_SLV    = 4,
  parameter int ADDR_W     = 16,
  parameter int SLV_ADDR_W = 12,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             h_address,
  input  logic                          h_read,
  input  logic                          h_write,
  input  logic [DATA_W-1:0]             h_writedata,
  output logic                          h_waitrequest,
  output logic [DATA_W-1:0]             h_readdata,
  output logic                          h_readdatavalid,
  output logic [1:0]                    h_response,
  output logic                          timeout_o,
  output logic [SLV_ADDR_W-1:0]         s_address,
  output logic [DATA_W-1:0]             s_writedata,
  output logic [NUM_SLV:0]              s_read,
  output logic [NUM_SLV:0]              s_write,
  input  logic [NUM_SLV:0]              s_waitrequest,
  input  logic [(NUM_SLV+1)*DATA_W-1:0] s_readdata,
  input  logic [NUM_SLV:0]              s_readdatavalid
);

  localparam int NP    = NUM_SLV + 1;
  localparam int SEL_W = $clog2(NP);
  localparam int IDX_W = ADDR_W - SLV_ADDR_W;

  state_t                r_state;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_rd;
  logic                  r_err;
  logic                  r_rd_got;
  logic                  r_timeout;
  logic [7:0]            r_cnt;
  logic [SLV_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;

  logic [IDX_W-1:0]      w_idx;
  logic [SEL_W-1:0]      w_sel;
  logic [DATA_W-1:0]     w_rdata;
  logic                  w_rdv;
  logic                  w_wait;
  logic                  w_cnt_max;

  assign w_idx     = h_address[ADDR_W-1:SLV_ADDR_W];
  assign w_sel     = (w_idx < IDX_W'(NUM_SLV)) ? SEL_W'(w_idx) : SEL_W'(NUM_SLV);
  assign w_cnt_max = (r_cnt == 8'(TIMEOUT));

  tsn_csr_port_mux #(
    .NUM_PORT (NP),
    .DATA_W   (DATA_W),
    .SEL_W    (SEL_W)
  ) u_port_mux (
    .i_sel           (r_sel),
    .i_readdata      (s_readdata),
    .i_readdatavalid (s_readdatavalid),
    .i_waitrequest   (s_waitrequest),
    .o_readdata      (w_rdata),
    .o_readdatavalid (w_rdv),
    .o_waitrequest   (w_wait)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_rd      <= 1'b0;
      r_err     <= 1'b0;
      r_rd_got  <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (h_read || h_write) begin
            r_sel    <= w_sel;
            r_rd     <= h_read;
            r_addr   <= h_address[SLV_ADDR_W-1:0];
            r_wdata  <= h_writedata;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_rd_got <= 1'b0;
            r_rdata  <= '0;
            r_state  <= CMD;
          end
        end
        CMD: begin
          r_cnt <= r_cnt + 8'd1;
          // Slaves may return data in the same cycle they drop waitrequest.
          if (r_rd && w_rdv) begin
            r_rdata  <= w_rdata;
            r_rd_got <= 1'b1;
          end
          if (!w_wait) begin
            r_state <= ACK;
          end else if (w_cnt_max) begin
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= ACK;
          end
        end
        ACK: begin
          if (r_rd && w_rdv) begin
            r_rdata  <= w_rdata;
            r_rd_got <= 1'b1;
          end
          if (!r_rd) begin
            r_state <= IDLE;
          end else if (r_rd_got || w_rdv || r_err) begin
            r_state <= RESP;
          end else begin
            r_cnt   <= '0;
            r_state <= RDWAIT;
          end
        end
        RDWAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_rdv) begin
            r_rdata <= w_rdata;
            r_state <= RESP;
          end else if (w_cnt_max) begin
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    s_read  = '0;
    s_write = '0;
    if (r_state == CMD) begin
      for (int k = 0; k < NP; k++) begin
        if (r_sel == SEL_W'(k)) begin
          s_read[k]  = r_rd;
          s_write[k] = !r_rd;
        end
      end
    end
  end

  assign s_address       = r_addr;
  assign s_writedata     = r_wdata;
  assign h_waitrequest   = (r_state != ACK);
  assign h_readdatavalid = (r_state == RESP);
  assign h_readdata      = (r_state == RESP && !r_err) ? r_rdata : '0;
  assign h_response      = (r_state == RESP && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign timeout_o       = r_timeout;

endmodule
